multi_debounced_counter: RTL and testbench

Parametrised successor to the single-button debounced counter. Debounces NUM_BTNS active-low raw button inputs, one independent state machine per channel, and produces per-channel debounced level, press and release pulses. A shared CNT_WIDTH up/down counter is driven by channel 0 (increment) and channel 1 (decrement), with selectable wrap or saturate mode. Sits between board pushbuttons and LED/user logic.

---
 rtl/multi_debounced_counter.sv | 194 +++++++++++++++++++
 tb/tb_multi_debounced_counter.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/multi_debounced_counter.sv
// multi_debounced_counter
//   Debounces NUM_BTNS active-low pushbuttons, one independent FSM per
//   channel, and reports a debounced level plus one-cycle press and release
//   pulses per channel. A shared up/down counter steps up on press[0] and
//   down on press[1], either wrapping or saturating at its bounds.
//
// Ports
//   clk            in   system clock
//   rst            in   synchronous active-high reset
//   btn_n          in   [NUM_BTNS] raw asynchronous buttons, 0 = pressed
//   btn_state      out  [NUM_BTNS] debounced level, 1 = pressed
//   press          out  [NUM_BTNS] one-cycle pulse per debounced press
//   release_pulse  out  [NUM_BTNS] one-cycle pulse per debounced release
//                       ("release" is a reserved word in SystemVerilog)
//   count          out  [CNT_WIDTH] shared counter value
//   limit          out  one-cycle pulse on wrap or on a step blocked at a bound
module multi_debounced_counter #(
    parameter int NUM_BTNS      = 4,
    parameter int MAX_CLK_COUNT = 4799,
    parameter int CNT_WIDTH     = 4,
    parameter int SATURATE      = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_BTNS-1:0]  btn_n,
    output logic [NUM_BTNS-1:0]  btn_state,
    output logic [NUM_BTNS-1:0]  press,
    output logic [NUM_BTNS-1:0]  release_pulse,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 limit
);

    localparam int DW = $clog2(MAX_CLK_COUNT + 1);
    localparam logic [DW-1:0] DB_MAX = DW'(MAX_CLK_COUNT);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    logic [NUM_BTNS-1:0] sync1_r;
    logic [NUM_BTNS-1:0] sync2_r;
    logic [NUM_BTNS-1:0] pressed_s;

    state_t              state_r [NUM_BTNS];
    state_t              state_s [NUM_BTNS];
    logic [DW-1:0]       dcnt_r  [NUM_BTNS];
    logic [DW-1:0]       dcnt_s  [NUM_BTNS];
    logic [NUM_BTNS-1:0] press_s;
    logic [NUM_BTNS-1:0] release_s;
    logic [NUM_BTNS-1:0] level_s;

    logic [CNT_WIDTH-1:0] count_s;
    logic                 limit_s;
    logic                 inc_s;
    logic                 dec_s;

    // Two-flop synchroniser per channel; idles at 1 (released).
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= '1;
            sync2_r <= '1;
        end else begin
            sync1_r <= btn_n;
            sync2_r <= sync1_r;
        end
    end

    assign pressed_s = ~sync2_r;

    // Per-channel debounce FSM: next state, window counter and event pulses.
    always_comb begin
        press_s   = '0;
        release_s = '0;
        level_s   = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            state_s[i] = state_r[i];
            dcnt_s[i]  = dcnt_r[i];
            case (state_r[i])
                IDLE: begin
                    if (pressed_s[i]) begin
                        state_s[i] = PRESS_WAIT;
                        dcnt_s[i]  = '0;
                    end else begin
                        state_s[i] = IDLE;
                    end
                end
                PRESS_WAIT: begin
                    if (!pressed_s[i]) begin
                        state_s[i] = IDLE;
                    end else if (dcnt_r[i] == DB_MAX) begin
                        state_s[i] = PRESSED;
                        press_s[i] = 1'b1;
                    end else begin
                        dcnt_s[i] = dcnt_r[i] + DW'(1);
                    end
                end
                PRESSED: begin
                    if (!pressed_s[i]) begin
                        state_s[i] = RELEASE_WAIT;
                        dcnt_s[i]  = '0;
                    end else begin
                        state_s[i] = PRESSED;
                    end
                end
                RELEASE_WAIT: begin
                    if (pressed_s[i]) begin
                        state_s[i] = PRESSED;
                    end else if (dcnt_r[i] == DB_MAX) begin
                        state_s[i]   = IDLE;
                        release_s[i] = 1'b1;
                    end else begin
                        dcnt_s[i] = dcnt_r[i] + DW'(1);
                    end
                end
                default: begin
                    state_s[i] = IDLE;
                    dcnt_s[i]  = '0;
                end
            endcase
            // Level follows the next state so it changes with the pulse.
            level_s[i] = (state_s[i] == PRESSED) || (state_s[i] == RELEASE_WAIT);
        end
    end

    // Debounce state, window counters and registered per-channel outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                state_r[i] <= IDLE;
                dcnt_r[i]  <= '0;
            end
            btn_state     <= '0;
            press         <= '0;
            release_pulse <= '0;
        end else begin
            for (int i = 0; i < NUM_BTNS; i++) begin
                state_r[i] <= state_s[i];
                dcnt_r[i]  <= dcnt_s[i];
            end
            btn_state     <= level_s;
            press         <= press_s;
            release_pulse <= release_s;
        end
    end

    // Counter step from the registered press pulses (one cycle behind them).
    always_comb begin
        inc_s   = press[0] & ~press[1];
        dec_s   = press[1] & ~press[0];
        count_s = count;
        limit_s = 1'b0;
        if (inc_s) begin
            if (count == {CNT_WIDTH{1'b1}}) begin
                limit_s = 1'b1;
                if (SATURATE == 0) begin
                    count_s = '0;
                end else begin
                    count_s = count;
                end
            end else begin
                count_s = count + CNT_WIDTH'(1);
            end
        end else if (dec_s) begin
            if (count == {CNT_WIDTH{1'b0}}) begin
                limit_s = 1'b1;
                if (SATURATE == 0) begin
                    count_s = '1;
                end else begin
                    count_s = count;
                end
            end else begin
                count_s = count - CNT_WIDTH'(1);
            end
        end else begin
            count_s = count;
            limit_s = 1'b0;
        end
    end

    // Shared counter and limit pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
            limit <= 1'b0;
        end else begin
            count <= count_s;
            limit <= limit_s;
        end
    end

endmodule

// File: tb/tb_multi_debounced_counter.sv
module tb_multi_debounced_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] btn_n = 4'b1111;

    logic [3:0] btn_state_w, press_w, release_w;
    logic [3:0] count_w;
    logic       limit_w;
    logic [3:0] btn_state_s, press_s, release_s;
    logic [3:0] count_s;
    logic       limit_s;

    int tests = 0;
    int fails = 0;
    int cyc;
    int press_cnt [4];
    int press_at  [4];
    int rel_cnt   [4];
    int rel_at    [4];
    int lim_w;
    int lim_s;
    int mode_diff = 0;

    always #5 clk = ~clk;

    multi_debounced_counter #(
        .NUM_BTNS(4), .MAX_CLK_COUNT(15), .CNT_WIDTH(4), .SATURATE(0)
    ) dut_w (
        .clk(clk), .rst(rst), .btn_n(btn_n),
        .btn_state(btn_state_w), .press(press_w), .release_pulse(release_w),
        .count(count_w), .limit(limit_w)
    );

    multi_debounced_counter #(
        .NUM_BTNS(4), .MAX_CLK_COUNT(15), .CNT_WIDTH(4), .SATURATE(1)
    ) dut_s (
        .clk(clk), .rst(rst), .btn_n(btn_n),
        .btn_state(btn_state_s), .press(press_s), .release_pulse(release_s),
        .count(count_s), .limit(limit_s)
    );

    task automatic clear_counts();
        cyc = 0;
        lim_w = 0;
        lim_s = 0;
        for (int i = 0; i < 4; i++) begin
            press_cnt[i] = 0; press_at[i] = 0;
            rel_cnt[i]   = 0; rel_at[i]   = 0;
        end
    endtask

    // One clock; outputs sampled on the falling edge and tallied.
    task automatic step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 4; i++) begin
            if (press_w[i] === 1'b1) begin
                if (press_cnt[i] == 0) press_at[i] = cyc;
                press_cnt[i]++;
            end
            if (release_w[i] === 1'b1) begin
                if (rel_cnt[i] == 0) rel_at[i] = cyc;
                rel_cnt[i]++;
            end
        end
        if (limit_w === 1'b1) lim_w++;
        if (limit_s === 1'b1) lim_s++;
        if (press_s !== press_w || release_s !== release_w || btn_state_s !== btn_state_w)
            mode_diff++;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_n = 4'b1111;
        step();
        step();
        rst = 1'b0;
        clear_counts();
    endtask

    task automatic press_once(input logic [3:0] mask);
        btn_n = ~mask;
        repeat (22) step();
        btn_n = 4'b1111;
        repeat (22) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_n = 4'b1111;
        step();
        step();
        tests++;
        if (btn_state_w !== 4'b0000 || press_w !== 4'b0000 || release_w !== 4'b0000 ||
            count_w !== 4'd0 || limit_w !== 1'b0 || count_s !== 4'd0 || limit_s !== 1'b0) begin
            fails++;
            $display("FAIL reset_outputs: state=%b press=%b rel=%b count=%0d limit=%b, need all 0",
                     btn_state_w, press_w, release_w, count_w, limit_w);
        end
        rst = 1'b0;
        clear_counts();
        btn_n = 4'b1110;
        repeat (20) step();
        tests++;
        if (press_at[0] != 19 || press_cnt[0] != 1) begin
            fails++;
            $display("FAIL first_press_timing: at=%0d n=%0d, need at=19 n=1", press_at[0], press_cnt[0]);
        end
        tests++;
        if (btn_state_w !== 4'b0001) begin
            fails++;
            $display("FAIL first_press_level: got %b need 0001", btn_state_w);
        end
        tests++;
        if (count_w !== 4'd1 || count_s !== 4'd1) begin
            fails++;
            $display("FAIL first_press_count: got %0d/%0d need 1", count_w, count_s);
        end
        btn_n = 4'b1111;
        repeat (22) step();
        tests++;
        if (rel_cnt[0] != 1 || btn_state_w !== 4'b0000) begin
            fails++;
            $display("FAIL first_release: n=%0d state=%b need n=1 state=0000", rel_cnt[0], btn_state_w);
        end
    endtask

    task automatic test_bounce();
        do_reset();
        for (int seg = 0; seg < 12; seg++) begin
            btn_n[0] = (seg % 2 == 1) ? 1'b1 : 1'b0;
            repeat (5) step();
        end
        tests++;
        if (press_cnt[0] != 0) begin
            fails++;
            $display("FAIL bounce_no_press: got %0d presses need 0", press_cnt[0]);
        end
        clear_counts();
        btn_n[0] = 1'b0;
        repeat (30) step();
        tests++;
        if (press_cnt[0] != 1 || press_at[0] != 19) begin
            fails++;
            $display("FAIL bounce_press: n=%0d at=%0d need n=1 at=19", press_cnt[0], press_at[0]);
        end
        clear_counts();
        btn_n[0] = 1'b1;
        repeat (30) step();
        tests++;
        if (rel_cnt[0] != 1 || rel_at[0] != 19) begin
            fails++;
            $display("FAIL bounce_release: n=%0d at=%0d need n=1 at=19", rel_cnt[0], rel_at[0]);
        end
    endtask

    task automatic test_wrap();
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            press_once(4'b0001);
            tests++;
            if (count_w !== 4'(i % 16) || lim_w != ((i == 16) ? 1 : 0)) begin
                fails++;
                $display("FAIL wrap_inc_%0d: count=%0d limits=%0d need count=%0d limits=%0d",
                         i, count_w, lim_w, i % 16, (i == 16) ? 1 : 0);
            end
        end
        clear_counts();
        press_once(4'b0010);
        tests++;
        if (count_w !== 4'd15 || lim_w != 1) begin
            fails++;
            $display("FAIL wrap_dec: count=%0d limits=%0d need 15 and 1", count_w, lim_w);
        end
    endtask

    task automatic test_saturate();
        do_reset();
        for (int i = 1; i <= 20; i++) begin
            press_once(4'b0001);
            tests++;
            if (count_s !== 4'((i > 15) ? 15 : i) || lim_s != ((i > 15) ? i - 15 : 0)) begin
                fails++;
                $display("FAIL sat_inc_%0d: count=%0d limits=%0d need count=%0d limits=%0d",
                         i, count_s, lim_s, (i > 15) ? 15 : i, (i > 15) ? i - 15 : 0);
            end
        end
        do_reset();
        press_once(4'b0010);
        tests++;
        if (count_s !== 4'd0 || lim_s != 1) begin
            fails++;
            $display("FAIL sat_dec: count=%0d limits=%0d need 0 and 1", count_s, lim_s);
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        press_once(4'b0011);
        tests++;
        if (press_cnt[0] != 1 || press_cnt[1] != 1 || press_at[0] != press_at[1]) begin
            fails++;
            $display("FAIL simul_press: n0=%0d n1=%0d at0=%0d at1=%0d need one each same cycle",
                     press_cnt[0], press_cnt[1], press_at[0], press_at[1]);
        end
        tests++;
        if (count_w !== 4'd0 || lim_w != 0 || count_s !== 4'd0 || lim_s != 0) begin
            fails++;
            $display("FAIL simul_count: count=%0d/%0d limits=%0d/%0d need 0", count_w, count_s, lim_w, lim_s);
        end
        clear_counts();
        press_once(4'b1000);
        tests++;
        if (press_cnt[3] != 1 || press_cnt[0] + press_cnt[1] + press_cnt[2] != 0 ||
            count_w !== 4'd0 || lim_w != 0) begin
            fails++;
            $display("FAIL chan3_only: n3=%0d others=%0d count=%0d limits=%0d need 1/0/0/0",
                     press_cnt[3], press_cnt[0] + press_cnt[1] + press_cnt[2], count_w, lim_w);
        end
    endtask

    task automatic test_reset_midwait();
        do_reset();
        btn_n = 4'b1110;
        repeat (10) step();
        rst = 1'b1;
        repeat (8) step();
        tests++;
        if (press_cnt[0] != 0 || btn_state_w !== 4'b0000) begin
            fails++;
            $display("FAIL midwait_no_press: n=%0d state=%b need 0/0000", press_cnt[0], btn_state_w);
        end
        rst = 1'b0;
        clear_counts();
        repeat (20) step();
        tests++;
        if (press_cnt[0] != 1 || press_at[0] != 19 || count_w !== 4'd1) begin
            fails++;
            $display("FAIL midwait_press: n=%0d at=%0d count=%0d need 1/19/1",
                     press_cnt[0], press_at[0], count_w);
        end
        btn_n = 4'b1111;
        repeat (22) step();
    endtask

    task automatic test_mode_agree();
        tests++;
        if (mode_diff != 0) begin
            fails++;
            $display("FAIL mode_events_agree: %0d differing cycles need 0", mode_diff);
        end
    endtask

    initial begin
        clear_counts();
        test_reset();
        test_bounce();
        test_wrap();
        test_saturate();
        test_simultaneous();
        test_reset_midwait();
        test_mode_agree();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
